// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C master read path.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        M_ACK,
        STOP
    } i2c_master_state_t;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;

endpackage

// File: rtl/i2c_scl_timer.sv
// SCL bit-slot phase counter; emits the per-slot strobes the master FSM keys off.
module i2c_scl_timer #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    output logic scl_high,
    output logic drive_tick,
    output logic mid_tick,
    output logic sample_tick,
    output logic slot_end
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PH_LAST   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_DRIVE  = PW'(1);
    localparam logic [PW-1:0] PH_MID    = PW'(CLK_DIV / 2);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(CLK_DIV / 2 + CLK_DIV / 4);

    logic [PW-1:0] phase;

    // Held at zero while disabled so the first enabled clock is phase 0 of slot 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase <= '0;
        end else if (!enable || phase == PH_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

    always_comb begin
        scl_high    = enable && (phase >= PH_MID);
        drive_tick  = enable && (phase == PH_DRIVE);
        mid_tick    = enable && (phase == PH_MID);
        sample_tick = enable && (phase == PH_SAMPLE);
        slot_end    = enable && (phase == PH_LAST);
    end

endmodule

// File: rtl/i2c_master_rx.sv
// Single-master I2C read initiator: START, address+R, N data bytes (ACK all but last), STOP.
module i2c_master_rx
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 10,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               go,
    input  logic [6:0]         slave_addr,
    input  logic [COUNT_W-1:0] byte_count,
    input  logic               sda_in,
    output logic               scl_out,
    output logic               sda_out,
    output logic [7:0]         rx_data,
    output logic               rx_valid,
    output logic               busy,
    output logic               done,
    output logic               nack_error
);

    i2c_master_state_t state, state_nxt;

    logic               sda_meta, sda_s;
    logic [6:0]         addr_q;
    logic [7:0]         addr_byte;
    logic [COUNT_W-1:0] remaining;
    logic [2:0]         bit_cnt;
    logic [6:0]         shift;
    logic               sda_q;
    logic               scl_high, drive_tick, mid_tick, sample_tick, slot_end;

    i2c_scl_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .enable     (state != IDLE),
        .scl_high   (scl_high),
        .drive_tick (drive_tick),
        .mid_tick   (mid_tick),
        .sample_tick(sample_tick),
        .slot_end   (slot_end)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sda_meta <= 1'b1;
            sda_s    <= 1'b1;
        end else begin
            sda_meta <= sda_in;
            sda_s    <= sda_meta;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scl_out   = scl_high;
        busy      = (state != IDLE);
        sda_out   = sda_q;
        addr_byte = {addr_q, I2C_RW_READ};
        unique case (state)
            IDLE: begin
                scl_out = 1'b1;
                if (go) state_nxt = START;
            end
            START: begin
                scl_out = 1'b1;
                if (slot_end) state_nxt = ADDR;
            end
            ADDR:     if (slot_end && bit_cnt == 3'd0) state_nxt = ADDR_ACK;
            ADDR_ACK: if (slot_end) state_nxt = (nack_error || remaining == '0) ? STOP : DATA;
            DATA:     if (slot_end && bit_cnt == 3'd0) state_nxt = M_ACK;
            M_ACK:    if (slot_end) state_nxt = (remaining == COUNT_W'(1)) ? STOP : DATA;
            STOP:     if (slot_end) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // bit_cnt is 3 bits wide, so decrementing past bit 0 reloads 7 for the next byte.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_q     <= '0;
            remaining  <= '0;
            bit_cnt    <= 3'd7;
            shift      <= '0;
            sda_q      <= 1'b1;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            done       <= 1'b0;
            nack_error <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        addr_q     <= slave_addr;
                        remaining  <= byte_count;
                        nack_error <= 1'b0;
                        bit_cnt    <= 3'd7;
                    end
                end
                START: begin
                    if (mid_tick) sda_q <= 1'b0;
                end
                ADDR: begin
                    if (drive_tick) sda_q <= addr_byte[bit_cnt];
                    if (slot_end) bit_cnt <= bit_cnt - 3'd1;
                end
                ADDR_ACK: begin
                    if (drive_tick) sda_q <= 1'b1;
                    if (sample_tick && sda_s == I2C_NACK) nack_error <= 1'b1;
                end
                DATA: begin
                    if (drive_tick) sda_q <= 1'b1;
                    if (sample_tick) begin
                        shift <= {shift[5:0], sda_s};
                        if (bit_cnt == 3'd0) begin
                            rx_data  <= {shift, sda_s};
                            rx_valid <= 1'b1;
                        end
                    end
                    if (slot_end) bit_cnt <= bit_cnt - 3'd1;
                end
                M_ACK: begin
                    if (drive_tick) sda_q <= (remaining == COUNT_W'(1)) ? I2C_NACK : I2C_ACK;
                    if (slot_end) remaining <= remaining - COUNT_W'(1);
                end
                STOP: begin
                    if (drive_tick) sda_q <= 1'b0;
                    if (sample_tick) sda_q <= 1'b1;
                    if (slot_end) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_rx.sv
// Self-checking bench for i2c_master_rx with a behavioural I2C slave and an rx_data scoreboard.
module tb_i2c_master_rx;

    localparam int CLK_DIV = 10;
    localparam int COUNT_W = 4;

    logic               tb_clk = 1'b0;
    logic               n_rst;
    logic               go;
    logic [6:0]         slave_addr;
    logic [COUNT_W-1:0] byte_count;
    logic               sda_in;
    logic               scl_out, sda_out;
    logic [7:0]         rx_data;
    logic               rx_valid, busy, done, nack_error;

    always #5 tb_clk = ~tb_clk;

    i2c_master_rx #(
        .CLK_DIV(CLK_DIV),
        .COUNT_W(COUNT_W)
    ) dut (
        .clk       (tb_clk),
        .n_rst     (n_rst),
        .go        (go),
        .slave_addr(slave_addr),
        .byte_count(byte_count),
        .sda_in    (sda_in),
        .scl_out   (scl_out),
        .sda_out   (sda_out),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .done      (done),
        .nack_error(nack_error)
    );

    // Wired-AND bus: master and slave can each only pull SDA low.
    logic sl_sda = 1'b1;
    assign sda_in = sda_out & sl_sda;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int accept_cyc;
    logic [7:0] exp_q[$];

    always @(posedge tb_clk) cyc++;

    // Slave configuration (written by the stimulus) and observations (written by the slave).
    logic [7:0] sl_data[8];
    logic       sl_ack_addr = 1'b1;
    int         sl_nbytes   = 0;
    int         sl_gen      = 0;
    int         sl_seen     = 0;
    int         sl_k = 0, sl_nk, sl_j, sl_b;
    int         start_cnt = 0, stop_cnt = 0;
    logic [7:0] cap_addr;
    logic       cap_mack[8];
    logic       p_scl = 1'b1, p_sda = 1'b1;

    // Rise k after START: 1..8 address, 9 address ACK, then 9 rises per data byte + master ACK.
    always @(negedge tb_clk) begin
        if (sl_gen != sl_seen) begin
            sl_seen   = sl_gen;
            sl_k      = 0;
            sl_sda    = 1'b1;
            start_cnt = 0;
            stop_cnt  = 0;
            cap_addr  = '0;
            for (int i = 0; i < 8; i++) cap_mack[i] = 1'bx;
        end else begin
            if (p_scl === 1'b1 && scl_out === 1'b1 && p_sda === 1'b1 && sda_in === 1'b0) begin
                start_cnt++;
                sl_k = 0;
            end
            if (p_scl === 1'b1 && scl_out === 1'b1 && p_sda === 1'b0 && sda_in === 1'b1) stop_cnt++;
            if (p_scl === 1'b0 && scl_out === 1'b1) begin
                sl_k++;
                if (sl_k <= 8) cap_addr = {cap_addr[6:0], sda_in};
                else if (sl_k >= 18 && (sl_k - 18) % 9 == 0 && (sl_k - 18) / 9 < 8)
                    cap_mack[(sl_k - 18) / 9] = sda_in;
            end
            if (p_scl === 1'b1 && scl_out === 1'b0) begin
                sl_nk  = sl_k + 1;
                sl_sda = 1'b1;
                if (sl_nk == 9) begin
                    sl_sda = sl_ack_addr ? 1'b0 : 1'b1;
                end else if (sl_nk >= 10 && sl_ack_addr) begin
                    sl_j = (sl_nk - 10) / 9;
                    sl_b = (sl_nk - 10) % 9;
                    if (sl_j < sl_nbytes && sl_b < 8) sl_sda = sl_data[sl_j][7 - sl_b];
                end
            end
        end
        p_scl = scl_out;
        p_sda = sda_in;
    end

    task automatic start_txn(input logic [6:0] a, input logic [COUNT_W-1:0] c, input logic ack);
        sl_ack_addr = ack;
        sl_nbytes   = int'(c);
        sl_gen++;
        if (ack) for (int j = 0; j < int'(c); j++) exp_q.push_back(sl_data[j]);
        @(negedge tb_clk);
        slave_addr = a;
        byte_count = c;
        go         = 1'b1;
        @(posedge tb_clk);
        @(negedge tb_clk);
        go         = 1'b0;
        accept_cyc = cyc;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_go: busy=%b required 1", busy);
        end
    endtask

    // Waits for done, popping the scoreboard on every rx_valid seen along the way.
    task automatic wait_done(input int budget, output int lat);
        logic [7:0] e;
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge tb_clk);
            if (rx_valid === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rx_extra: rx_valid with rx_data=%h, no byte expected", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        n_fail++;
                        $display("FAIL rx_data: got %h required %h", rx_data, e);
                    end
                end
            end
            if (done === 1'b1) begin
                lat = cyc - accept_cyc;
                break;
            end
        end
        n_tests++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d clocks", budget);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rx_missing: %0d bytes not received, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge tb_clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b busy=%b one clock later, required 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        go = 1'b0;
        slave_addr = '0;
        byte_count = '0;
        repeat (3) @(negedge tb_clk);
        n_tests++;
        if ({scl_out, sda_out, rx_data, rx_valid, busy, done, nack_error} !== {2'b11, 8'h00, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_values: scl=%b sda=%b rx=%h v=%b busy=%b done=%b nack=%b required 1 1 00 0 0 0 0",
                     scl_out, sda_out, rx_data, rx_valid, busy, done, nack_error);
        end
        n_rst = 1'b1;
        repeat (5) @(negedge tb_clk);
        n_tests++;
        if ({scl_out, sda_out, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL idle_after_reset: scl=%b sda=%b busy=%b required 1 1 0", scl_out, sda_out, busy);
        end
    endtask

    task automatic test_single_read();
        int lat;
        sl_data[0] = 8'hF1;
        start_txn(7'h3C, 4'd1, 1'b1);
        wait_done(1000, lat);
        n_tests++;
        if (lat !== 200) begin
            n_fail++;
            $display("FAIL single_latency: got %0d clocks required 200", lat);
        end
        n_tests++;
        if (cap_addr !== 8'h79) begin
            n_fail++;
            $display("FAIL single_addr_bits: got %b required 01111001", cap_addr);
        end
        n_tests++;
        if (cap_mack[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_nack_last: got %b required 1", cap_mack[0]);
        end
        n_tests++;
        if (start_cnt !== 1 || stop_cnt !== 1 || nack_error !== 1'b0) begin
            n_fail++;
            $display("FAIL single_frame: starts=%0d stops=%0d nack=%b required 1 1 0", start_cnt, stop_cnt, nack_error);
        end
    endtask

    task automatic test_multi_read();
        int lat;
        sl_data[0] = 8'hA5;
        sl_data[1] = 8'h5A;
        sl_data[2] = 8'hFF;
        start_txn(7'h55, 4'd3, 1'b1);
        wait_done(2000, lat);
        n_tests++;
        if (lat !== (2 + 9 + 27) * CLK_DIV) begin
            n_fail++;
            $display("FAIL multi_latency: got %0d clocks required %0d", lat, (2 + 9 + 27) * CLK_DIV);
        end
        n_tests++;
        if ({cap_mack[0], cap_mack[1], cap_mack[2]} !== 3'b001) begin
            n_fail++;
            $display("FAIL multi_master_ack: got %b%b%b required 001", cap_mack[0], cap_mack[1], cap_mack[2]);
        end
        n_tests++;
        if (cap_addr !== 8'hAB || stop_cnt !== 1) begin
            n_fail++;
            $display("FAIL multi_frame: addr=%h stops=%0d required ab 1", cap_addr, stop_cnt);
        end
    endtask

    // A NACKed address goes straight to STOP, the same 11 slots as a zero-length probe.
    task automatic test_addr_nack();
        int lat;
        sl_data[0] = 8'h00;
        sl_data[1] = 8'h00;
        start_txn(7'h12, 4'd2, 1'b0);
        wait_done(1000, lat);
        n_tests++;
        if (lat !== 11 * CLK_DIV) begin
            n_fail++;
            $display("FAIL nack_latency: got %0d clocks required %0d", lat, 11 * CLK_DIV);
        end
        n_tests++;
        if (nack_error !== 1'b1 || stop_cnt !== 1) begin
            n_fail++;
            $display("FAIL nack_flag: nack=%b stops=%0d required 1 1", nack_error, stop_cnt);
        end
    endtask

    task automatic test_probe();
        int lat;
        start_txn(7'h40, 4'd0, 1'b1);
        n_tests++;
        if (nack_error !== 1'b0) begin
            n_fail++;
            $display("FAIL probe_nack_clear: nack=%b required 0 after go", nack_error);
        end
        wait_done(1000, lat);
        n_tests++;
        if (lat !== 11 * CLK_DIV) begin
            n_fail++;
            $display("FAIL probe_latency: got %0d clocks required %0d", lat, 11 * CLK_DIV);
        end
        n_tests++;
        if (nack_error !== 1'b0 || cap_addr !== 8'h81 || stop_cnt !== 1) begin
            n_fail++;
            $display("FAIL probe_frame: nack=%b addr=%h stops=%0d required 0 81 1", nack_error, cap_addr, stop_cnt);
        end
    endtask

    task automatic test_go_ignored();
        int lat;
        sl_data[0] = 8'h12;
        sl_data[1] = 8'h34;
        start_txn(7'h51, 4'd2, 1'b1);
        repeat (50) @(negedge tb_clk);
        slave_addr = 7'h22;
        byte_count = 4'd5;
        go = 1'b1;
        @(negedge tb_clk);
        go = 1'b0;
        wait_done(2000, lat);
        n_tests++;
        if (lat !== 29 * CLK_DIV) begin
            n_fail++;
            $display("FAIL go_ignored_latency: got %0d clocks required %0d", lat, 29 * CLK_DIV);
        end
        n_tests++;
        if (cap_addr !== 8'hA3 || start_cnt !== 1) begin
            n_fail++;
            $display("FAIL go_ignored_addr: addr=%h starts=%0d required a3 1", cap_addr, start_cnt);
        end
        repeat (20) @(negedge tb_clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL go_not_queued: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int saw_done;
        sl_data[0] = 8'hF1;
        start_txn(7'h3C, 4'd1, 1'b1);
        exp_q.delete();
        repeat (143) @(negedge tb_clk);
        n_tests++;
        if (busy !== 1'b1 || scl_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_data_state: busy=%b scl=%b required 1 0", busy, scl_out);
        end
        #1 n_rst = 1'b0;
        #1;
        n_tests++;
        if ({scl_out, sda_out, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_release: scl=%b sda=%b busy=%b required 1 1 0", scl_out, sda_out, busy);
        end
        saw_done = 0;
        repeat (3) begin
            @(negedge tb_clk);
            if (done === 1'b1 || rx_valid === 1'b1) saw_done++;
        end
        n_rst = 1'b1;
        sl_gen++;
        repeat (30) begin
            @(negedge tb_clk);
            if (done === 1'b1 || rx_valid === 1'b1 || busy !== 1'b0) saw_done++;
        end
        n_tests++;
        if (saw_done !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: %0d cycles with done/rx_valid/busy, required 0", saw_done);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_multi_read();
        test_addr_nack();
        test_probe();
        test_go_ignored();
        test_reset_mid();
        test_single_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
